wptr_ctrl: RTL and testbench

WPTR_CTRL -- requirements
Module: wptr_ctrl

---
 rtl/async_fifo_pkg.sv | 34 +++
 rtl/sync_nff.sv | 32 +++
 rtl/wptr_ctrl.sv | 104 ++++++++++
 tb/tb_wptr_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// +----------------------------------------------------------------------+
// | async_fifo_pkg : pointer helpers shared by the async FIFO domains    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package async_fifo_pkg;

  // One spare bit above the widest legal pointer keeps slices of helper results non-empty.
  localparam int MAX_PTR_W = 14;

  typedef logic [MAX_PTR_W-1:0] ptr_t;

  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_nff.sv
// +----------------------------------------------------------------------+
// | sync_nff : multi-flop synchronizer with asynchronous active-low reset|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module sync_nff #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [STAGES-1:0][WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/wptr_ctrl.sv
// +----------------------------------------------------------------------+
// | wptr_ctrl : async FIFO write-side pointer, full/level/overflow logic  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module wptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   g_rptr_async,
  input  logic [ADDR_W:0]   af_thresh,
  input  logic              clr_ovf,
  output logic              wmem_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   b_wptr,
  output logic [ADDR_W:0]   g_wptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel,
  output logic              overflow
);

  localparam int c_ptr_w = ptr_w(ADDR_W);

  logic [c_ptr_w-1:0] r_b_wptr;
  logic [c_ptr_w-1:0] r_g_wptr;
  logic               r_full;
  logic               r_almost_full;
  logic [c_ptr_w-1:0] r_wlevel;
  logic               r_overflow;

  logic [c_ptr_w-1:0] w_g_rptr_s;
  logic [c_ptr_w-1:0] w_b_rptr_s;
  logic [c_ptr_w-1:0] w_b_wptr_nxt;
  logic [c_ptr_w-1:0] w_g_wptr_nxt;
  logic [c_ptr_w-1:0] w_level_nxt;
  logic [c_ptr_w-1:0] w_full_cmp;
  logic               w_wr_ok;
  ptr_t               w_b_rptr_ext;
  ptr_t               w_g_wptr_ext;
  logic               w_unused_hi;

  sync_nff #(
    .WIDTH  (c_ptr_w),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .i_d   (g_rptr_async),
    .o_q   (w_g_rptr_s)
  );

  // Helpers work on a fixed wide type; upper bits of zero-extended inputs stay zero.
  assign w_b_rptr_ext = gray2bin(ptr_t'(w_g_rptr_s));
  assign w_b_rptr_s   = w_b_rptr_ext[c_ptr_w-1:0];

  assign w_wr_ok      = wr_en & ~r_full;
  assign w_b_wptr_nxt = r_b_wptr + {{ADDR_W{1'b0}}, w_wr_ok};
  assign w_g_wptr_ext = bin2gray(ptr_t'(w_b_wptr_nxt));
  assign w_g_wptr_nxt = w_g_wptr_ext[c_ptr_w-1:0];
  assign w_level_nxt  = w_b_wptr_nxt - w_b_rptr_s;

  assign w_unused_hi  = ^{w_b_rptr_ext[MAX_PTR_W-1:c_ptr_w], w_g_wptr_ext[MAX_PTR_W-1:c_ptr_w]};

  // Full in gray space: write pointer one lap ahead of the synchronized read pointer.
  assign w_full_cmp   = {~w_g_rptr_s[c_ptr_w-1:c_ptr_w-2], w_g_rptr_s[c_ptr_w-3:0]};

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_b_wptr      <= '0;
      r_g_wptr      <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
      r_wlevel      <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_b_wptr      <= w_b_wptr_nxt;
      r_g_wptr      <= w_g_wptr_nxt;
      r_full        <= (w_g_wptr_nxt == w_full_cmp);
      r_almost_full <= (w_level_nxt >= af_thresh);
      r_wlevel      <= w_level_nxt;
      r_overflow    <= (wr_en & r_full) | (r_overflow & ~clr_ovf);
    end
  end

  assign wmem_en     = w_wr_ok;
  assign waddr       = r_b_wptr[ADDR_W-1:0];
  assign b_wptr      = r_b_wptr;
  assign g_wptr      = r_g_wptr;
  assign full        = r_full;
  assign almost_full = r_almost_full;
  assign wlevel      = r_wlevel;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_wptr_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_wptr_ctrl : self-checking bench for wptr_ctrl (ADDR_W=3, 2 stages)|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_wptr_ctrl;

  localparam int AW    = 3;
  localparam int SS    = 2;
  localparam int DEPTH = 8;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic          clr_ovf = 1'b0;
  logic [AW:0]   g_rptr_async = '0;
  logic [AW:0]   af_thresh = 4'd6;
  logic          wmem_en;
  logic [AW-1:0] waddr;
  logic [AW:0]   b_wptr;
  logic [AW:0]   g_wptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wlevel;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain entry counts; the read count becomes visible SS edges late.
  int m_w;
  int m_r;
  int m_q[SS];
  int m_level;
  bit m_full;
  bit m_af;
  bit m_ovf;

  wptr_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .wr_en        (wr_en),
    .g_rptr_async (g_rptr_async),
    .af_thresh    (af_thresh),
    .clr_ovf      (clr_ovf),
    .wmem_en      (wmem_en),
    .waddr        (waddr),
    .b_wptr       (b_wptr),
    .g_wptr       (g_wptr),
    .full         (full),
    .almost_full  (almost_full),
    .wlevel       (wlevel),
    .overflow     (overflow)
  );

  always #5 wclk = ~wclk;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = 0; m_level = 0;
    for (int i = 0; i < SS; i++) m_q[i] = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  task automatic assert_reset();
    @(negedge wclk);
    #2;
    wrst_n = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0; g_rptr_async = '0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // One write-clock cycle: drive, sample the strobe, clock, advance the model.
  task automatic step(input logic we, input logic clr, output logic wm_seen, output logic wm_exp);
    bit ok;
    @(negedge wclk);
    wr_en = we; clr_ovf = clr; g_rptr_async = 4'(gray(m_r % 16));
    #1;
    wm_seen = wmem_en;
    wm_exp  = we & ~m_full;
    @(posedge wclk);
    ok    = we && !m_full;
    m_ovf = (we && m_full) || (m_ovf && !clr);
    m_w   = m_w + (ok ? 1 : 0);
    m_level = m_w - m_q[0];
    m_full  = (m_level == DEPTH);
    m_af    = (m_level >= int'(af_thresh));
    for (int i = 0; i < SS - 1; i++) m_q[i] = m_q[i+1];
    m_q[SS-1] = m_r;
    #1;
  endtask

  task automatic test_reset();
    assert_reset();
    n_tests++; if (b_wptr !== 4'd0) begin n_fail++; $display("FAIL reset_b_wptr got %0h exp 0", b_wptr); end
    n_tests++; if (g_wptr !== 4'd0) begin n_fail++; $display("FAIL reset_g_wptr got %0h exp 0", g_wptr); end
    n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL reset_waddr got %0h exp 0", waddr); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b exp 0", full); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %0b exp 0", almost_full); end
    n_tests++; if (wlevel !== 4'd0) begin n_fail++; $display("FAIL reset_wlevel got %0h exp 0", wlevel); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", overflow); end
    n_tests++; if (wmem_en !== 1'b0) begin n_fail++; $display("FAIL reset_wmem_en got %0b exp 0", wmem_en); end
    release_reset();
  endtask

  task automatic test_fill();
    logic wm, wme;
    af_thresh = 4'd6;
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++; if (waddr !== 3'(i)) begin n_fail++; $display("FAIL fill_waddr got %0d exp %0d", waddr, i); end
      step(1'b1, 1'b0, wm, wme);
      n_tests++; if (wm !== 1'b1) begin n_fail++; $display("FAIL fill_wmem_en got %0b exp 1", wm); end
    end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b exp 1", full); end
    n_tests++; if (wlevel !== 4'd8) begin n_fail++; $display("FAIL fill_wlevel got %0d exp 8", wlevel); end
    n_tests++; if (g_wptr !== 4'b1100) begin n_fail++; $display("FAIL fill_g_wptr got %b exp 1100", g_wptr); end
    n_tests++; if (b_wptr !== 4'd8) begin n_fail++; $display("FAIL fill_b_wptr got %0d exp 8", b_wptr); end
  endtask

  task automatic test_overflow();
    logic wm, wme;
    step(1'b1, 1'b0, wm, wme);
    n_tests++; if (wm !== 1'b0) begin n_fail++; $display("FAIL ovf_wmem_en got %0b exp 0", wm); end
    n_tests++; if (b_wptr !== 4'd8) begin n_fail++; $display("FAIL ovf_b_wptr got %0d exp 8", b_wptr); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %0b exp 1", overflow); end
    step(1'b0, 1'b1, wm, wme);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b exp 0", overflow); end
    step(1'b1, 1'b1, wm, wme);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %0b exp 1", overflow); end
    step(1'b0, 1'b1, wm, wme);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear2 got %0b exp 0", overflow); end
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_still_full got %0b exp 1", full); end
  endtask

  task automatic test_read_visible();
    logic wm, wme;
    m_r = 1;
    for (int e = 1; e <= SS + 1; e++) begin
      step(1'b0, 1'b0, wm, wme);
      n_tests++; if (full !== (e <= SS)) begin n_fail++; $display("FAIL rdvis_full edge %0d got %0b exp %0b", e, full, (e <= SS)); end
    end
    n_tests++; if (wlevel !== 4'd7) begin n_fail++; $display("FAIL rdvis_wlevel got %0d exp 7", wlevel); end
  endtask

  task automatic test_almost_full();
    logic wm, wme;
    assert_reset();
    release_reset();
    af_thresh = 4'd6;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0, wm, wme);
      n_tests++; if (almost_full !== (i >= 6)) begin n_fail++; $display("FAIL af_edge %0d got %0b exp %0b", i, almost_full, (i >= 6)); end
    end
  endtask

  task automatic test_wrap();
    logic wm, wme;
    assert_reset();
    release_reset();
    for (int i = 0; i < 20; i++) begin
      m_r = (m_w > 3) ? m_w - 3 : 0;
      step(1'b1, 1'b0, wm, wme);
      n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL wrap_full cyc %0d got %0b exp 0", i, full); end
      n_tests++; if (wlevel !== 4'(m_level)) begin n_fail++; $display("FAIL wrap_wlevel cyc %0d got %0d exp %0d", i, wlevel, m_level); end
    end
    n_tests++; if (b_wptr !== 4'(20 % 16)) begin n_fail++; $display("FAIL wrap_b_wptr got %0d exp 4", b_wptr); end
  endtask

  task automatic test_reset_midburst();
    logic wm, wme;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, wm, wme);
    assert_reset();
    n_tests++; if ({b_wptr, g_wptr, waddr, full, almost_full, wlevel, overflow, wmem_en} !== '0) begin
      n_fail++; $display("FAIL midrst_outputs got b=%0h g=%0h a=%0h f=%0b af=%0b l=%0h o=%0b w=%0b exp all 0",
                         b_wptr, g_wptr, waddr, full, almost_full, wlevel, overflow, wmem_en);
    end
    release_reset();
    n_tests++; if (waddr !== 3'd0) begin n_fail++; $display("FAIL midrst_waddr got %0d exp 0", waddr); end
    step(1'b1, 1'b0, wm, wme);
    n_tests++; if (b_wptr !== 4'd1) begin n_fail++; $display("FAIL midrst_b_wptr got %0d exp 1", b_wptr); end
  endtask

  task automatic test_random();
    logic wm, wme;
    logic we, clr;
    assert_reset();
    af_thresh = 4'($urandom_range(0, DEPTH));
    release_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 50) af_thresh = 4'($urandom_range(0, DEPTH));
      if (($urandom % 2 == 0) && (m_r < m_w)) m_r++;
      we  = ($urandom % 4) != 0;
      clr = ($urandom % 8) == 0;
      step(we, clr, wm, wme);
      n_tests++; if (wm !== wme) begin n_fail++; $display("FAIL rnd_wmem_en cyc %0d got %0b exp %0b", i, wm, wme); end
      n_tests++; if (b_wptr !== 4'(m_w % 16)) begin n_fail++; $display("FAIL rnd_b_wptr cyc %0d got %0d exp %0d", i, b_wptr, m_w % 16); end
      n_tests++; if (g_wptr !== 4'(gray(m_w % 16))) begin n_fail++; $display("FAIL rnd_g_wptr cyc %0d got %b exp %b", i, g_wptr, 4'(gray(m_w % 16))); end
      n_tests++; if (waddr !== 3'(m_w % 8)) begin n_fail++; $display("FAIL rnd_waddr cyc %0d got %0d exp %0d", i, waddr, m_w % 8); end
      n_tests++; if (full !== m_full) begin n_fail++; $display("FAIL rnd_full cyc %0d got %0b exp %0b", i, full, m_full); end
      n_tests++; if (almost_full !== m_af) begin n_fail++; $display("FAIL rnd_af cyc %0d got %0b exp %0b", i, almost_full, m_af); end
      n_tests++; if (wlevel !== 4'(m_level)) begin n_fail++; $display("FAIL rnd_wlevel cyc %0d got %0d exp %0d", i, wlevel, m_level); end
      n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf cyc %0d got %0b exp %0b", i, overflow, m_ovf); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_read_visible();
    test_almost_full();
    test_wrap();
    test_reset_midburst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
